// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds px/py from the active-low sync pair,
// checks each line and frame against the nominal timing and counts violations.
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2,
    parameter int H_TIMEOUT    = 1023
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pix_tick_i,
    input  logic       h_sync_i,
    input  logic       v_sync_i,
    output logic [9:0] px_o,
    output logic [9:0] py_o,
    output logic       video_on_o,
    output logic       frame_start_o,
    output logic       locked_o,
    output logic [7:0] err_count_o
);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS      = 10'(H_SYNC_START);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS      = 10'(V_SYNC_START);
    localparam logic [9:0] TO_PRE    = 10'(H_TIMEOUT - 1);
    localparam logic [9:0] TO_MAX    = 10'h3FF;
    localparam logic [3:0] GOOD_LAST = 4'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_H_SEEN,
        ST_ALIGN,
        ST_LOCKED
    } state_t;

    state_t     state_q;
    logic [3:0] good_q;
    logic       locked_q;
    logic [7:0] err_q;
    logic       h_prev_q, h_prev_d;
    logic       v_prev_q, v_prev_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [9:0] to_q, to_d;
    logic       frame_start_q, frame_start_d;
    logic       hfall_s, vfall_s, hwrap_s, mismatch_s, timeout_s, bad_s, checking_s;

    // Sync edge events and the timing checks made on the same tick.
    always_comb begin
        hfall_s    = pix_tick_i & h_prev_q & ~h_sync_i;
        vfall_s    = pix_tick_i & v_prev_q & ~v_sync_i;
        hwrap_s    = (hc_q == H_LAST);
        mismatch_s = (hfall_s & (hc_q != H_SS)) |
                     (vfall_s & ((vc_q != V_SS) | (hc_q != 10'd0)));
        timeout_s  = pix_tick_i & ~hfall_s & (to_q == TO_PRE);
        bad_s      = mismatch_s | timeout_s;
        checking_s = (state_q == ST_ALIGN) | (state_q == ST_LOCKED);
    end

    // Next values of the edge history, position counters and line timeout.
    always_comb begin
        h_prev_d      = h_prev_q;
        v_prev_d      = v_prev_q;
        hc_d          = hc_q;
        vc_d          = vc_q;
        to_d          = to_q;
        frame_start_d = 1'b0;
        if (pix_tick_i) begin
            h_prev_d = h_sync_i;
            v_prev_d = v_sync_i;
            // The falling tick itself is pixel H_SYNC_START, so the next one is +1.
            if (hfall_s) begin
                hc_d = H_SS + 10'd1;
            end else if (hwrap_s) begin
                hc_d = 10'd0;
            end else begin
                hc_d = hc_q + 10'd1;
            end
            if (vfall_s) begin
                vc_d = V_SS;
            end else if (hwrap_s) begin
                vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
            end else begin
                vc_d = vc_q;
            end
            if (hfall_s) begin
                to_d = 10'd0;
            end else if (to_q != TO_MAX) begin
                to_d = to_q + 10'd1;
            end else begin
                to_d = to_q;
            end
            frame_start_d = ~vfall_s & hwrap_s & (vc_q == V_LAST);
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_prev_q      <= 1'b1;
            v_prev_q      <= 1'b1;
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            to_q          <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            h_prev_q      <= h_prev_d;
            v_prev_q      <= v_prev_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            to_q          <= to_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Lock state machine with its registered lock flag and error counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_SEARCH;
            good_q   <= 4'd0;
            locked_q <= 1'b0;
            err_q    <= 8'd0;
        end else begin
            if (mismatch_s && checking_s && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
            case (state_q)
                ST_SEARCH: begin
                    locked_q <= 1'b0;
                    if (hfall_s) begin
                        state_q <= ST_H_SEEN;
                    end
                end
                ST_H_SEEN: begin
                    locked_q <= 1'b0;
                    if (timeout_s) begin
                        state_q <= ST_SEARCH;
                    end else if (vfall_s) begin
                        state_q <= ST_ALIGN;
                        good_q  <= 4'd0;
                    end
                end
                ST_ALIGN: begin
                    if (bad_s) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                    end else if (vfall_s && (good_q == GOOD_LAST)) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end else if (vfall_s) begin
                        good_q   <= good_q + 4'd1;
                        locked_q <= 1'b0;
                    end else begin
                        locked_q <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (bad_s) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                    end else begin
                        locked_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign px_o          = hc_q;
    assign py_o          = vc_q;
    assign frame_start_o = frame_start_q;
    assign locked_o      = locked_q;
    assign err_count_o   = err_q;
    assign video_on_o    = locked_q & (hc_q < H_ACT) & (vc_q < V_ACT);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: full-size instance for hand vectors and the 1023-tick
// timeout, plus a reduced-timing instance driven by a small sync generator model.
module tb_vga_sync_decoder;

    localparam int SH  = 40;
    localparam int SHA = 32;
    localparam int SHS = 34;
    localparam int SV  = 12;
    localparam int SVA = 8;
    localparam int SVS = 9;
    localparam int STO = 63;

    logic clk = 1'b0;
    logic reset, pix_tick, h_sync, v_sync;
    logic [9:0] f_px, f_py, s_px, s_py;
    logic f_vo, f_fs, f_lk, s_vo, s_fs, s_lk;
    logic [7:0] f_err, s_err;

    int checks = 0;
    int errors = 0;
    int g_h, g_v, line_len, vs_start, cyc;
    logic hs_en, gh_prev, gv_prev;

    typedef struct packed {
        logic       t;
        logic       h;
        logic       v;
        logic [9:0] px;
        logic [9:0] py;
        logic [7:0] err;
    } vec_t;
    vec_t tbl [14];

    vga_sync_decoder u_full (
        .clk_i(clk), .reset_i(reset), .pix_tick_i(pix_tick),
        .h_sync_i(h_sync), .v_sync_i(v_sync),
        .px_o(f_px), .py_o(f_py), .video_on_o(f_vo), .frame_start_o(f_fs),
        .locked_o(f_lk), .err_count_o(f_err)
    );

    vga_sync_decoder #(
        .H_TOTAL(SH), .H_ACTIVE(SHA), .H_SYNC_START(SHS),
        .V_TOTAL(SV), .V_ACTIVE(SVA), .V_SYNC_START(SVS),
        .LOCK_FRAMES(2), .H_TIMEOUT(STO)
    ) u_small (
        .clk_i(clk), .reset_i(reset), .pix_tick_i(pix_tick),
        .h_sync_i(h_sync), .v_sync_i(v_sync),
        .px_o(s_px), .py_o(s_py), .video_on_o(s_vo), .frame_start_o(s_fs),
        .locked_o(s_lk), .err_count_o(s_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic h, input logic v);
        pix_tick = t;
        h_sync   = h;
        v_sync   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        pix_tick = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        gh_prev = 1'b1;
        gv_prev = 1'b1;
    endtask

    task automatic gen_tick(output logic t, output logic hf, output logic vf, output logic fs_exp);
        logic h, v;
        t   = ((cyc % 7) != 6);
        cyc = cyc + 1;
        h   = hs_en ? !(g_h >= SHS && g_h < SHS + 4) : 1'b1;
        v   = !(g_v >= vs_start && g_v < vs_start + 2);
        hf  = t && gh_prev && !h;
        vf  = t && gv_prev && !v;
        fs_exp = t && (g_h == SH - 1) && (g_v == SV - 1);
        if (t) begin
            gh_prev = h;
            gv_prev = v;
            if (g_h == line_len - 1) begin
                g_h      = 0;
                line_len = SH;
                g_v      = (g_v == SV - 1) ? 0 : g_v + 1;
            end else begin
                g_h = g_h + 1;
            end
        end
        step(t, h, v);
    endtask

    // Lock is expected from the third v_sync fall after the first h_sync fall.
    task automatic run_lock(input int n, input string tag);
        logic t, hf, vf, fse, seen, exp_lk;
        int nv;
        nv   = 0;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            gen_tick(t, hf, vf, fse);
            if (vf && seen) nv++;
            if (hf) seen = 1'b1;
            exp_lk = (nv >= 3);
            chk({tag, "_locked"}, s_lk, exp_lk);
            if (exp_lk) begin
                chk({tag, "_px"}, s_px, g_h);
                chk({tag, "_py"}, s_py, g_v);
                chk({tag, "_frame_start"}, s_fs, fse);
                chk({tag, "_video_on"}, s_vo, (g_h < SHA) && (g_v < SVA));
            end else begin
                chk({tag, "_video_on_unlocked"}, s_vo, 0);
            end
        end
    endtask

    initial begin
        logic t, hf, vf, fse;
        int k;
        reset = 1'b1; pix_tick = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
        g_h = 0; g_v = 0; line_len = SH; vs_start = SVS; cyc = 0;
        hs_en = 1'b1; gh_prev = 1'b1; gv_prev = 1'b1;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 10'd1,   10'd0,   8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 10'd1,   10'd0,   8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 10'd657, 10'd0,   8'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 10'd658, 10'd490, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 10'd659, 10'd490, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 10'd657, 10'd490, 8'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 10'd658, 10'd490, 8'd1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 10'd657, 10'd490, 8'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 10'd658, 10'd490, 8'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 10'd659, 10'd490, 8'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 10'd660, 10'd490, 8'd1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 10'd661, 10'd490, 8'd2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 10'd661, 10'd490, 8'd2};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 10'd657, 10'd490, 8'd2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_px", f_px, 0);
        chk("rst_py", f_py, 0);
        chk("rst_video_on", f_vo, 0);
        chk("rst_frame_start", f_fs, 0);
        chk("rst_locked", f_lk, 0);
        chk("rst_err", f_err, 0);
        chk("rst_small_px", s_px, 0);
        chk("rst_small_locked", s_lk, 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].t, tbl[i].h, tbl[i].v);
            chk($sformatf("vec%0d_px", i), f_px, tbl[i].px);
            chk($sformatf("vec%0d_py", i), f_py, tbl[i].py);
            chk($sformatf("vec%0d_err", i), f_err, tbl[i].err);
            chk($sformatf("vec%0d_locked", i), f_lk, 0);
        end

        // Full-size timeout: alive after 1022 ticks without h fall, gone at 1023.
        pulse_reset();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 1021; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("to_a_py", f_py, 490);
        step(1'b1, 1'b0, 1'b1);
        chk("to_a_err", f_err, 1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 1021; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("to_b_err_at_timeout", f_err, 1);
        step(1'b1, 1'b0, 1'b1);
        chk("to_b_err", f_err, 1);

        // Clean source, reset released mid-frame.
        reset = 1'b1;
        g_h = 17; g_v = 5;
        pulse_reset();
        run_lock(2200, "clean");
        chk("clean_err", s_err, 0);

        // One 41-tick line: next h fall lands one pixel late.
        for (int i = 0; i < 1000 && !(g_h == 0 && g_v == 3); i++) gen_tick(t, hf, vf, fse);
        line_len = SH + 1;
        for (int i = 0; i < 1000; i++) begin
            gen_tick(t, hf, vf, fse);
            if (hf && g_v == 4) break;
            chk("long_line_locked_before", s_lk, 1);
        end
        chk("long_line_locked", s_lk, 0);
        chk("long_line_err", s_err, 1);
        run_lock(1800, "relock1");
        chk("relock1_err", s_err, 1);

        // v_sync falls one line late.
        for (int i = 0; i < 1000 && !(g_h == 0 && g_v == 0); i++) gen_tick(t, hf, vf, fse);
        vs_start = SVS + 1;
        for (int i = 0; i < 1000; i++) begin
            gen_tick(t, hf, vf, fse);
            if (vf) break;
            chk("late_v_locked_before", s_lk, 1);
        end
        vs_start = SVS;
        chk("late_v_py", s_py, SVS);
        chk("late_v_err", s_err, 2);
        chk("late_v_locked", s_lk, 0);
        run_lock(2000, "relock2");

        // h_sync held high while locked.
        for (int i = 0; i < 1000; i++) begin
            gen_tick(t, hf, vf, fse);
            if (hf) break;
        end
        hs_en = 1'b0;
        k = 0;
        for (int i = 0; i < 200 && k < 70; i++) begin
            gen_tick(t, hf, vf, fse);
            if (t) begin
                k++;
                chk($sformatf("hold_locked_k%0d", k), s_lk, (k < STO) ? 1 : 0);
            end
        end
        chk("hold_err", s_err, 2);
        for (int i = 0; i < 200 && !(g_h < 30); i++) gen_tick(t, hf, vf, fse);
        hs_en = 1'b1;
        run_lock(2000, "relock3");

        // Asynchronous reset mid-line while locked.
        for (int i = 0; i < 200 && g_h != 20; i++) gen_tick(t, hf, vf, fse);
        chk("pre_reset_locked", s_lk, 1);
        pix_tick = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_px", s_px, 0);
        chk("mid_rst_py", s_py, 0);
        chk("mid_rst_video_on", s_vo, 0);
        chk("mid_rst_frame_start", s_fs, 0);
        chk("mid_rst_locked", s_lk, 0);
        chk("mid_rst_err", s_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        gh_prev = 1'b1;
        gv_prev = 1'b1;
        run_lock(2000, "relock4");
        chk("relock4_err", s_err, 0);

        // Repeated ALIGN entries each ending in a misplaced h fall.
        pulse_reset();
        for (int i = 1; i <= 300; i++) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b1, 1'b1);
            if (i == 10)  chk("sat_err_10", s_err, 10);
            if (i == 255) chk("sat_err_255", s_err, 255);
        end
        chk("sat_err_300", s_err, 255);
        chk("sat_locked", s_lk, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
